// File: rtl/trail_stack_if.sv
// Command/response bundle between the solver engines and the assignment trail.
// The master drives commands; the slave (trail_stack) returns popped entries and status.
interface trail_stack_if #(
    parameter int VAR_W = 8,
    parameter int CNT_W = 8
);
    logic             en;
    logic             push;
    logic             pop;
    logic             backtrack;
    logic             type_in;
    logic             val_in;
    logic [VAR_W-1:0] variable_in;
    logic             out_valid;
    logic             type_out;
    logic             val_out;
    logic [VAR_W-1:0] variable_out;
    logic             bt_done;
    logic             bt_root;
    logic             busy;
    logic             empty;
    logic             full;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] level;
    logic             err;

    modport master (
        output en, push, pop, backtrack, type_in, val_in, variable_in,
        input  out_valid, type_out, val_out, variable_out,
        input  bt_done, bt_root, busy, empty, full, count, level, err
    );

    modport slave (
        input  en, push, pop, backtrack, type_in, val_in, variable_in,
        output out_valid, type_out, val_out, variable_out,
        output bt_done, bt_root, busy, empty, full, count, level, err
    );
endinterface

// File: rtl/trail_stack.sv
// Assignment trail: LIFO of {type, val, variable} with push/pop/replace and a
// multi-cycle unwind to (and including) the most recent decision.
module trail_stack #(
    parameter int NUM_VARIABLE = 128,
    parameter int VAR_W        = $clog2(NUM_VARIABLE) + 1,
    parameter int CNT_W        = $clog2(NUM_VARIABLE + 1)
) (
    input  logic           clk,
    input  logic           reset,
    trail_stack_if.slave   bus
);
    localparam int AW = (NUM_VARIABLE > 1) ? $clog2(NUM_VARIABLE) : 1;
    localparam int EW = VAR_W + 2;

    typedef enum logic {S_IDLE, S_UNWIND} state_t;

    logic [EW-1:0]    r_mem [NUM_VARIABLE];
    state_t           r_state, w_state_nx;
    logic [CNT_W-1:0] r_count, w_count_nx;
    logic [CNT_W-1:0] r_level, w_level_nx;
    logic             r_err, w_err_nx;
    logic             r_out_valid, w_out_valid_nx;
    logic             r_bt_done, w_bt_done_nx;
    logic             r_bt_root, w_bt_root_nx;
    logic [EW-1:0]    r_entry, w_entry_nx;

    logic             w_we;
    logic [AW-1:0]    w_waddr;
    logic [AW-1:0]    w_top_addr;
    logic [EW-1:0]    w_top;
    logic [EW-1:0]    w_wdata;
    logic             w_top_type;
    logic             w_empty;
    logic             w_full;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CNT_W'(NUM_VARIABLE));
    assign w_top_addr = AW'(r_count - CNT_W'(1));
    assign w_top      = r_mem[w_top_addr];
    assign w_top_type = w_top[EW-1];
    assign w_wdata    = {bus.type_in, bus.val_in, bus.variable_in};

    always_comb begin
        w_state_nx     = r_state;
        w_count_nx     = r_count;
        w_level_nx     = r_level;
        w_err_nx       = r_err;
        w_out_valid_nx = 1'b0;
        w_bt_done_nx   = 1'b0;
        w_bt_root_nx   = 1'b0;
        w_entry_nx     = r_entry;
        w_we           = 1'b0;
        w_waddr        = r_count[AW-1:0];
        case (r_state)
            S_IDLE: begin
                if (bus.backtrack) begin
                    if (w_empty) begin
                        w_bt_done_nx = 1'b1;
                        w_bt_root_nx = 1'b1;
                    end else begin
                        w_state_nx = S_UNWIND;
                    end
                end else if (bus.push && bus.pop) begin
                    // Replace top: old entry streams out, new one lands in the same slot
                    if (w_empty) begin
                        w_err_nx = 1'b1;
                    end else begin
                        w_out_valid_nx = 1'b1;
                        w_entry_nx     = w_top;
                        w_we           = 1'b1;
                        w_waddr        = w_top_addr;
                        w_level_nx     = r_level - CNT_W'(w_top_type) + CNT_W'(bus.type_in);
                    end
                end else if (bus.push) begin
                    if (w_full) begin
                        w_err_nx = 1'b1;
                    end else begin
                        w_we       = 1'b1;
                        w_count_nx = r_count + CNT_W'(1);
                        w_level_nx = r_level + CNT_W'(bus.type_in);
                    end
                end else if (bus.pop) begin
                    if (w_empty) begin
                        w_err_nx = 1'b1;
                    end else begin
                        w_out_valid_nx = 1'b1;
                        w_entry_nx     = w_top;
                        w_count_nx     = r_count - CNT_W'(1);
                        w_level_nx     = r_level - CNT_W'(w_top_type);
                    end
                end
            end
            S_UNWIND: begin
                w_out_valid_nx = 1'b1;
                w_entry_nx     = w_top;
                w_count_nx     = r_count - CNT_W'(1);
                if (w_top_type) begin
                    w_level_nx   = r_level - CNT_W'(1);
                    w_bt_done_nx = 1'b1;
                    w_state_nx   = S_IDLE;
                end else if (r_count == CNT_W'(1)) begin
                    w_bt_done_nx = 1'b1;
                    w_bt_root_nx = 1'b1;
                    w_state_nx   = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_level     <= '0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
            r_bt_done   <= 1'b0;
            r_bt_root   <= 1'b0;
            r_entry     <= '0;
        end else if (bus.en) begin
            r_state     <= w_state_nx;
            r_count     <= w_count_nx;
            r_level     <= w_level_nx;
            r_err       <= w_err_nx;
            r_out_valid <= w_out_valid_nx;
            r_bt_done   <= w_bt_done_nx;
            r_bt_root   <= w_bt_root_nx;
            r_entry     <= w_entry_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.en && w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    assign bus.out_valid    = r_out_valid;
    assign bus.type_out     = r_entry[EW-1];
    assign bus.val_out      = r_entry[EW-2];
    assign bus.variable_out = r_entry[VAR_W-1:0];
    assign bus.bt_done      = r_bt_done;
    assign bus.bt_root      = r_bt_root;
    assign bus.busy         = (r_state == S_UNWIND);
    assign bus.empty        = w_empty;
    assign bus.full         = w_full;
    assign bus.count        = r_count;
    assign bus.level        = r_level;
    assign bus.err          = r_err;
endmodule

// File: tb/tb_trail_stack.sv
// Scoreboard bench for trail_stack: stimulus queues expected pops, a monitor
// compares every out_valid/bt_done event; status is checked directly.
module tb_trail_stack;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    trail_stack_if #(.VAR_W(8), .CNT_W(8)) bus ();

    trail_stack #(.NUM_VARIABLE(128), .VAR_W(8), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic       ov;
        logic       bd;
        logic       br;
        logic       t;
        logic       v;
        logic [7:0] vr;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_out(input logic ov, input logic bd, input logic br,
                              input logic t, input logic v, input logic [7:0] vr);
        exp_t e;
        e = '{ov: ov, bd: bd, br: br, t: t, v: v, vr: vr};
        sb.push_back(e);
    endtask

    task automatic drive(input logic p, input logic q, input logic b,
                         input logic t, input logic v, input logic [7:0] vr);
        @(negedge clk);
        bus.en          = 1'b1;
        bus.push        = p;
        bus.pop         = q;
        bus.backtrack   = b;
        bus.type_in     = t;
        bus.val_in      = v;
        bus.variable_in = vr;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        bus.en = 1'b1; bus.push = 1'b0; bus.pop = 1'b0; bus.backtrack = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!bus.busy) break;
            @(negedge clk);
        end
        chk(name, int'(bus.busy), 0);
    endtask

    // Monitor: one scoreboard entry per enabled cycle carrying a pulse
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(posedge clk);
            #1;
            if (reset && bus.en && (bus.out_valid || bus.bt_done)) begin
                a = '{ov: bus.out_valid, bd: bus.bt_done, br: bus.bt_root,
                      t: bus.type_out, v: bus.val_out, vr: bus.variable_out};
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: got %h expected none", a);
                end else begin
                    e = sb.pop_front();
                    if (!e.ov) begin
                        a.t = 1'b0; a.v = 1'b0; a.vr = 8'd0;
                    end
                    if (a != e) begin
                        errors++;
                        $display("FAIL sb_out: got ov%0b bd%0b br%0b t%0b v%0b var%0d expected ov%0b bd%0b br%0b t%0b v%0b var%0d",
                                 a.ov, a.bd, a.br, a.t, a.v, a.vr, e.ov, e.bd, e.br, e.t, e.v, e.vr);
                    end
                end
            end
        end
    end

    initial begin
        bus.en = 1'b1; bus.push = 1'b0; bus.pop = 1'b0; bus.backtrack = 1'b0;
        bus.type_in = 1'b0; bus.val_in = 1'b0; bus.variable_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_count", int'(bus.count), 0);
        chk("rst_empty", int'(bus.empty), 1);
        chk("rst_outs", int'({bus.out_valid, bus.bt_done, bus.bt_root, bus.busy, bus.err, bus.full}), 0);
        reset = 1'b1;

        // 1: push three, pop three
        drive(1, 0, 0, 1, 1, 8'd3);
        drive(1, 0, 0, 0, 0, 8'd5);
        drive(1, 0, 0, 0, 1, 8'd9);
        idle();
        chk("t1_count", int'(bus.count), 3);
        chk("t1_level", int'(bus.level), 1);
        expect_out(1, 0, 0, 0, 1, 8'd9);
        drive(0, 1, 0, 0, 0, 8'd0);
        expect_out(1, 0, 0, 0, 0, 8'd5);
        drive(0, 1, 0, 0, 0, 8'd0);
        idle();
        chk("t1_level_mid", int'(bus.level), 1);
        expect_out(1, 0, 0, 1, 1, 8'd3);
        drive(0, 1, 0, 0, 0, 8'd0);
        idle();
        chk("t1_level_end", int'(bus.level), 0);
        chk("t1_empty", int'(bus.empty), 1);

        // 2: backtrack to last decision
        drive(1, 0, 0, 1, 1, 8'd1);
        drive(1, 0, 0, 0, 0, 8'd2);
        drive(1, 0, 0, 1, 1, 8'd4);
        drive(1, 0, 0, 0, 0, 8'd6);
        drive(1, 0, 0, 0, 1, 8'd7);
        expect_out(1, 0, 0, 0, 1, 8'd7);
        expect_out(1, 0, 0, 0, 0, 8'd6);
        expect_out(1, 1, 0, 1, 1, 8'd4);
        drive(0, 0, 1, 0, 0, 8'd0);
        drive(1, 1, 1, 1, 1, 8'd99);  // ignored while busy
        idle();
        chk("t2_busy", int'(bus.busy), 1);
        wait_idle("t2_timeout", 10);
        chk("t2_count", int'(bus.count), 2);
        chk("t2_level", int'(bus.level), 1);
        chk("t2_err", int'(bus.err), 0);
        expect_out(1, 0, 0, 0, 0, 8'd2);
        expect_out(1, 1, 0, 1, 1, 8'd1);
        drive(0, 0, 1, 0, 0, 8'd0);
        idle();
        wait_idle("t2b_timeout", 10);
        chk("t2b_empty", int'(bus.empty), 1);

        // 3: backtrack with no decision, then on empty stack
        drive(1, 0, 0, 0, 0, 8'd2);
        drive(1, 0, 0, 0, 1, 8'd8);
        expect_out(1, 0, 0, 0, 1, 8'd8);
        expect_out(1, 1, 1, 0, 0, 8'd2);
        drive(0, 0, 1, 0, 0, 8'd0);
        idle();
        wait_idle("t3_timeout", 10);
        chk("t3_empty", int'(bus.empty), 1);
        chk("t3_level", int'(bus.level), 0);
        expect_out(0, 1, 1, 0, 0, 8'd0);
        drive(0, 0, 1, 0, 0, 8'd0);
        idle();
        chk("t3_busy_empty", int'(bus.busy), 0);

        // 4: fill, overflow, replace on full
        for (int i = 0; i < 128; i++) begin
            logic [7:0] vi;
            vi = 8'(i);
            drive(1, 0, 0, (i % 32) == 0, vi[0], vi);
        end
        idle();
        chk("t4_full", int'(bus.full), 1);
        chk("t4_level", int'(bus.level), 4);
        chk("t4_err_pre", int'(bus.err), 0);
        drive(1, 0, 0, 0, 0, 8'd200);
        idle();
        chk("t4_count_ovf", int'(bus.count), 128);
        chk("t4_err", int'(bus.err), 1);
        expect_out(1, 0, 0, 0, 1, 8'd127);
        drive(1, 1, 0, 1, 1, 8'd77);
        idle();
        chk("t4_count_rep", int'(bus.count), 128);
        chk("t4_level_rep", int'(bus.level), 5);
        expect_out(1, 0, 0, 1, 1, 8'd77);
        drive(0, 1, 0, 0, 0, 8'd0);
        idle();
        chk("t4_count_pop", int'(bus.count), 127);
        chk("t4_level_pop", int'(bus.level), 4);

        // 5: underflow, then reset mid-unwind
        do_reset();
        drive(0, 1, 0, 0, 0, 8'd0);
        idle();
        chk("t5_ov", int'(bus.out_valid), 0);
        chk("t5_err", int'(bus.err), 1);
        for (int i = 1; i <= 5; i++) drive(1, 0, 0, 0, 0, 8'(i));
        expect_out(1, 0, 0, 0, 0, 8'd5);
        drive(0, 0, 1, 0, 0, 8'd0);
        idle();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t5_count", int'(bus.count), 0);
        chk("t5_busy", int'(bus.busy), 0);
        chk("t5_outs", int'({bus.out_valid, bus.bt_done, bus.bt_root, bus.err, bus.type_out, bus.val_out, bus.variable_out}), 0);
        @(negedge clk);
        reset = 1'b1;

        // 6: en=0 freezes unwind
        drive(1, 0, 0, 1, 1, 8'd20);
        drive(1, 0, 0, 0, 0, 8'd21);
        drive(1, 0, 0, 0, 1, 8'd22);
        drive(1, 0, 0, 0, 0, 8'd23);
        expect_out(1, 0, 0, 0, 0, 8'd23);
        expect_out(1, 0, 0, 0, 1, 8'd22);
        expect_out(1, 0, 0, 0, 0, 8'd21);
        expect_out(1, 1, 0, 1, 1, 8'd20);
        drive(0, 0, 1, 0, 0, 8'd0);
        idle();
        @(negedge clk);
        bus.en = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_count_frz", int'(bus.count), 3);
        chk("t6_ov_held", int'(bus.out_valid), 1);
        chk("t6_var_held", int'(bus.variable_out), 23);
        chk("t6_busy_frz", int'(bus.busy), 1);
        bus.en = 1'b1;
        wait_idle("t6_timeout", 10);
        chk("t6_count", int'(bus.count), 0);
        chk("t6_level", int'(bus.level), 0);

        repeat (3) @(negedge clk);
        chk("sb_drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
